mux_l1_tx: RTL and testbench

Transmit-side 4:1 byte interleaver for phy_tx. It is the inverse of the phy_rx demux tree. It samples four parallel 8-bit lanes, each with its own valid, once per frame of four clk_4f cycles. It then serialises them onto one 8-bit stream plus valid, in lane order 0,1,2,3. All logic runs on clk_4f; the 1/4-rate lane timing comes from an internal phase counter, not from separate clocks.

---
 rtl/phy_pkg.sv | 15 +
 rtl/phase_gen_4.sv | 22 ++
 rtl/mux_l1_tx.sv | 62 ++++++
 tb/tb_mux_l1_tx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared constants and types for the phy_tx / phy_rx lane datapaths.
package phy_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int LANES      = 4;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_LAST = 2'd3;

  function automatic phase_t phase_inc(input phase_t p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/phase_gen_4.sv
// Free-running 4-phase counter on the serial clock, with the lane capture strobe.
module phase_gen_4
  import phy_pkg::*;
(
  input  logic       clk_4f,
  input  logic       reset,
  output logic [1:0] phase,
  output logic       lane_sample
);

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      phase <= '0;
    end else begin
      phase <= phase_inc(phase);
    end
  end

  // Strobe is suppressed while reset is held so a phase==3 reset edge never captures.
  assign lane_sample = (phase == PH_LAST) & ~reset;

endmodule

// File: rtl/mux_l1_tx.sv
// 4:1 byte interleaver: captures four lanes once per frame and serialises them in lane order.
module mux_l1_tx
  import phy_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_DATA = '0
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  input  logic              valid_0,
  input  logic              valid_1,
  input  logic              valid_2,
  input  logic              valid_3,
  output logic              lane_sample,
  output logic [DATA_W-1:0] data_000,
  output logic              valid_000
);

  logic [1:0]        phase;
  logic [DATA_W-1:0] hold [LANES];
  logic [LANES-1:0]  hold_v;
  logic              primed;

  phase_gen_4 u_phase (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .phase       (phase),
    .lane_sample (lane_sample)
  );

  // Emission reads hold with the pre-edge phase, so lane 3 of the old frame leaves
  // on the same edge that reloads hold with the next frame.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        hold[i] <= '0;
      end
      hold_v    <= '0;
      primed    <= 1'b0;
      data_000  <= IDLE_DATA;
      valid_000 <= 1'b0;
    end else begin
      if (primed) begin
        data_000  <= hold[phase];
        valid_000 <= hold_v[phase];
      end
      if (lane_sample) begin
        hold[0] <= data_0;
        hold[1] <= data_1;
        hold[2] <= data_2;
        hold[3] <= data_3;
        hold_v  <= {valid_3, valid_2, valid_1, valid_0};
        primed  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_l1_tx.sv
// Randomised and directed bench for mux_l1_tx against a frame-queue reference model.
module tb_mux_l1_tx;

  logic       clk_4f;
  logic       reset;
  logic [7:0] data_0, data_1, data_2, data_3;
  logic       valid_0, valid_1, valid_2, valid_3;
  logic       lane_sample;
  logic [7:0] data_000;
  logic       valid_000;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: edges since reset release, and a queue of {valid,data} slots.
  int         n_edge = 0;
  logic [8:0] q[$];
  logic [7:0] exp_d = 8'h00;
  logic       exp_v = 1'b0;

  mux_l1_tx #(.DATA_W(8), .IDLE_DATA(8'h00)) dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .data_0      (data_0),
    .data_1      (data_1),
    .data_2      (data_2),
    .data_3      (data_3),
    .valid_0     (valid_0),
    .valid_1     (valid_1),
    .valid_2     (valid_2),
    .valid_3     (valid_3),
    .lane_sample (lane_sample),
    .data_000    (data_000),
    .valid_000   (valid_000)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_lanes(input logic [31:0] d, input logic [3:0] v);
    data_0 = d[7:0];
    data_1 = d[15:8];
    data_2 = d[23:16];
    data_3 = d[31:24];
    {valid_3, valid_2, valid_1, valid_0} = v;
  endtask

  task automatic tick;
    @(posedge clk_4f);
    if (reset) begin
      n_edge = 0;
      q.delete();
      exp_d = 8'h00;
      exp_v = 1'b0;
    end else begin
      n_edge++;
      if (q.size() > 0) {exp_v, exp_d} = q.pop_front();
      if (n_edge % 4 == 0) begin
        q.push_back({valid_0, data_0});
        q.push_back({valid_1, data_1});
        q.push_back({valid_2, data_2});
        q.push_back({valid_3, data_3});
      end
    end
    @(negedge clk_4f);
    check("data", {24'h0, data_000}, {24'h0, exp_d});
    check("valid", {31'h0, valid_000}, {31'h0, exp_v});
    check("lane_sample", {31'h0, lane_sample},
          {31'h0, ((n_edge % 4 == 3) && !reset)});
  endtask

  // Fill non-sample cycles with junk, present the frame in the sample cycle.
  task automatic drive_frame(input logic [31:0] d, input logic [3:0] v, input logic [7:0] junk);
    int g;
    g = 0;
    while ((n_edge % 4 != 3) && (g < 8)) begin
      set_lanes({4{junk}}, 4'($urandom_range(0, 15)));
      tick();
      g++;
    end
    set_lanes(d, v);
    tick();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      set_lanes($urandom, 4'($urandom_range(0, 15)));
      tick();
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
  endtask

  // Right after release: idle for edges 1-4, then DD EE CC BB valid on edges 5-8.
  task automatic first_frame_after_reset;
    logic [7:0] s1 [4];
    s1 = '{8'hDD, 8'hEE, 8'hCC, 8'hBB};
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) set_lanes(32'hBBCCEEDD, 4'hF);
      else        set_lanes($urandom, 4'($urandom_range(0, 15)));
      tick();
      check("s1_valid", {31'h0, valid_000}, {31'h0, (k >= 5)});
      if (k >= 5) check("s1_data", {24'h0, data_000}, {24'h0, s1[k-5]});
      else        check("s1_idle", {24'h0, data_000}, 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_lanes(32'h0, 4'h0);

    do_reset();
    first_frame_after_reset();

    drive_frame(32'h44332211, 4'hF, 8'h00);
    drive_frame(32'h778899AA ^ 32'h00003300 ^ 32'h00003300, 4'hF, 8'h00);
    idle(8);

    drive_frame(32'h77778888, 4'b0101, 8'h00);
    idle(4);

    drive_frame(32'h5A5A5A5A, 4'hF, 8'hFF);
    idle(6);

    // Reset while lane 1 of 11/22/33/44 is on the output.
    drive_frame(32'h44332211, 4'hF, 8'h00);
    tick();
    tick();
    check("mid_lane1", {24'h0, data_000}, 32'h22);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", {31'h0, valid_000}, 32'h0);
    check("mid_rst_data", {24'h0, data_000}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    first_frame_after_reset();

    // Reset arriving on a phase==3 edge must not capture.
    drive_frame(32'h0, 4'h0, 8'h00);
    while (n_edge % 4 != 3) idle(1);
    set_lanes(32'hC3C3C3C3, 4'hF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(6);

    for (int f = 0; f < 64; f++) begin
      drive_frame($urandom, 4'($urandom_range(0, 15)), 8'($urandom));
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "timeout");
  end

endmodule
